// File: rtl/ps2_ctrl_pkg.sv
// Shared types and constants for the PS/2 key event controller:
// prefix FSM states, prefix byte values and event-word layout.
package ps2_ctrl_pkg;

  localparam int unsigned EVT_W       = 10;
  localparam int unsigned EVT_BRK_BIT = 9;
  localparam int unsigned EVT_EXT_BIT = 8;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  // Assemble an event word from the prefix flags and the scan code.
  function automatic logic [EVT_W-1:0] make_evt(input logic brk, input logic ext,
                                                input logic [7:0] code);
    logic [EVT_W-1:0] e;
    e              = '0;
    e[EVT_BRK_BIT] = brk;
    e[EVT_EXT_BIT] = ext;
    e[7:0]         = code;
    return e;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO for key events; rdata is the head entry,
// or zero while empty. A push while full is accepted only alongside a pop.
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage needs no reset: rdata is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Merges E0/F0 prefixes with scan codes into key events, buffers them for the CPU.
// Define PS2_KEY_EVENT_OVF_EN to enable the sticky overflow flag.
module ps2_key_event_ctrl
  import ps2_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   dec_int_clear,
  input  logic                   irq_en,
  input  logic                   rd_pop,
  output logic [EVT_W-1:0]       evt_data,
  output logic                   evt_avail,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   irq,
  output logic                   overflow,
  input  logic                   ovf_clear
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e       state_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             dec_int_clear_q;
  logic             is_pfx_c, push_c, empty, full, drop;
  logic [EVT_W-1:0] push_data_c;

  assign is_pfx_c    = (in_data == PS2_PREFIX_EXT) || (in_data == PS2_PREFIX_BRK);
  assign push_c      = in_valid && !is_pfx_c;
  assign push_data_c = make_evt((state_q == ST_BRK) || (state_q == ST_EXT_BRK),
                                (state_q == ST_EXT) || (state_q == ST_EXT_BRK),
                                in_data);

  // Prefix sequencer with idle timeout, plus decoder interrupt-clear pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      to_cnt_q        <= '0;
      dec_int_clear_q <= 1'b0;
    end else begin
      dec_int_clear_q <= in_valid;
      if (in_valid) begin
        to_cnt_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (in_data == PS2_PREFIX_EXT)      state_q <= ST_EXT;
            else if (in_data == PS2_PREFIX_BRK) state_q <= ST_BRK;
          end
          ST_EXT: begin
            if (in_data == PS2_PREFIX_BRK)      state_q <= ST_EXT_BRK;
            else if (in_data != PS2_PREFIX_EXT) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q == ST_IDLE) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_q  <= ST_IDLE;
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH(DEPTH),
    .W    (EVT_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push_c),
    .wdata(push_data_c),
    .pop  (rd_pop),
    .rdata(evt_data),
    .full (full),
    .empty(empty),
    .drop (drop),
    .count(evt_count)
  );

  assign dec_int_clear = dec_int_clear_q;
  assign evt_avail     = !empty;
  assign irq           = irq_en && !empty;

`ifdef PS2_KEY_EVENT_OVF_EN
  logic ovf_q;

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          ovf_q <= 1'b0;
    else if (drop)      ovf_q <= 1'b1;
    else if (ovf_clear) ovf_q <= 1'b0;
  end

  assign overflow = ovf_q;

  logic unused_full;
  assign unused_full = full;
`else
  assign overflow = 1'b0;

  logic unused_ovf;
  assign unused_ovf = &{1'b0, ovf_clear, drop, full};
`endif

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed + randomized bench for ps2_key_event_ctrl against a queue-based
// model of prefix merging, FIFO occupancy and overflow.
module tb_ps2_key_event_ctrl;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 25000;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       dec_int_clear;
  logic       irq_en;
  logic       rd_pop;
  logic [9:0] evt_data;
  logic       evt_avail;
  logic [3:0] evt_count;
  logic       irq;
  logic       overflow;
  logic       ovf_clear;

  ps2_key_event_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .dec_int_clear(dec_int_clear), .irq_en(irq_en), .rd_pop(rd_pop),
    .evt_data(evt_data), .evt_avail(evt_avail), .evt_count(evt_count),
    .irq(irq), .overflow(overflow), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pending prefix flags, idle time, event queue, overflow, last valid.
  bit         m_ext, m_brk;
  int         m_idle;
  logic [9:0] mq[$];
  bit         m_ovf;
  bit         m_dic;
  int         dic_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_cycle(input bit v, input logic [7:0] d, input bit pop, input bit clr);
    bit         push, popped, drop;
    logic [9:0] ev;
    push = 0;
    ev   = '0;
    if (v) begin
      m_idle = 0;
      if (d == 8'hE0 || d == 8'hF0) begin
        // A prefix after a break prefix is a protocol error; otherwise it accumulates.
        if (m_brk) begin m_ext = 0; m_brk = 0; end
        else if (d == 8'hE0) m_ext = 1;
        else m_brk = 1;
      end else begin
        push  = 1;
        ev    = {m_brk, m_ext, d};
        m_ext = 0;
        m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle >= TIMEOUT) begin m_ext = 0; m_brk = 0; m_idle = 0; end
    end else begin
      m_idle = 0;
    end
    popped = pop && (mq.size() > 0);
    drop   = push && (mq.size() == DEPTH) && !popped;
    if (popped) void'(mq.pop_front());
    if (push && !drop) mq.push_back(ev);
`ifdef PS2_KEY_EVENT_OVF_EN
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
`else
    m_ovf = 0;
`endif
    m_dic = v;
  endtask

  task automatic check_all(input string tag);
    logic [9:0] head;
    head = (mq.size() > 0) ? mq[0] : 10'h000;
    chk({tag, ".evt_data"},  32'(evt_data),      32'(head));
    chk({tag, ".evt_avail"}, 32'(evt_avail),     32'(mq.size() > 0));
    chk({tag, ".evt_count"}, 32'(evt_count),     32'(mq.size()));
    chk({tag, ".irq"},       32'(irq),           32'(irq_en && (mq.size() > 0)));
    chk({tag, ".overflow"},  32'(overflow),      32'(m_ovf));
    chk({tag, ".dic"},       32'(dec_int_clear), 32'(m_dic));
  endtask

  // One clock: inputs held across the edge, outputs checked #1 afterwards.
  task automatic cyc(input bit v, input logic [7:0] d, input bit pop, input bit clr,
                     input bit do_chk, input string tag);
    in_valid  = v;
    in_data   = d;
    rd_pop    = pop;
    ovf_clear = clr;
    @(posedge clk);
    #1;
    in_valid  = 0;
    rd_pop    = 0;
    ovf_clear = 0;
    model_cycle(v, d, pop, clr);
    if (dec_int_clear) dic_seen++;
    if (do_chk) check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #3 reset = 1;
    #1;
    mq.delete();
    m_ext = 0; m_brk = 0; m_idle = 0; m_ovf = 0; m_dic = 0;
    chk({tag, ".rst_data"},  32'(evt_data),      32'h0);
    chk({tag, ".rst_avail"}, 32'(evt_avail),     32'h0);
    chk({tag, ".rst_count"}, 32'(evt_count),     32'h0);
    chk({tag, ".rst_irq"},   32'(irq),           32'h0);
    chk({tag, ".rst_ovf"},   32'(overflow),      32'h0);
    chk({tag, ".rst_dic"},   32'(dec_int_clear), 32'h0);
    @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 8'h00, 1, 0, 1, tag);
  endtask

  initial begin
    reset = 1; in_valid = 0; in_data = 0; rd_pop = 0; ovf_clear = 0; irq_en = 0;
    dic_seen = 0;
    @(posedge clk);
    #1;
    do_reset("init");

    // Make and break of the same key.
    dic_seen = 0;
    cyc(1, 8'h1C, 0, 0, 1, "mk");
    cyc(1, 8'hF0, 0, 0, 1, "brk_pfx");
    cyc(1, 8'h1C, 0, 0, 1, "brk");
    cyc(0, 8'h00, 0, 0, 1, "brk_idle");
    chk("dic_pulses", 32'(dic_seen), 32'd3);
    chk("cnt2", 32'(evt_count), 32'd2);
    chk("head_01C", 32'(evt_data), 32'h01C);
    cyc(0, 8'h00, 1, 0, 1, "pop1");
    chk("head_21C", 32'(evt_data), 32'h21C);
    drain("drain1");

    // Extended break and extended make.
    cyc(1, 8'hE0, 0, 0, 1, "e0");
    cyc(1, 8'hF0, 0, 0, 1, "e0f0");
    chk("no_evt_pfx", 32'(evt_count), 32'd0);
    cyc(1, 8'h75, 0, 0, 1, "ext_brk");
    chk("ev_375", 32'(evt_data), 32'h375);
    cyc(1, 8'hE0, 0, 0, 1, "e0b");
    cyc(1, 8'h74, 0, 0, 1, "ext_mk");
    cyc(0, 8'h00, 1, 0, 1, "pop375");
    chk("ev_174", 32'(evt_data), 32'h174);
    drain("drain2");

    // Prefix abandoned after an idle timeout.
    cyc(1, 8'hE0, 0, 0, 1, "to_e0");
    for (int i = 0; i < TIMEOUT + 1; i++) cyc(0, 8'h00, 0, 0, 0, "to_wait");
    cyc(1, 8'h1C, 0, 0, 1, "to_1c");
    chk("to_ev", 32'(evt_data), 32'h01C);
    drain("drain3");
    // A short gap keeps the prefix.
    cyc(1, 8'hE0, 0, 0, 1, "keep_e0");
    for (int i = 0; i < 50; i++) cyc(0, 8'h00, 0, 0, 0, "keep_wait");
    cyc(1, 8'h6B, 0, 0, 1, "keep_6b");
    chk("keep_ev", 32'(evt_data), 32'h16B);
    drain("drain3b");
    // F0 F0 is a protocol error.
    cyc(1, 8'hF0, 0, 0, 1, "ff0");
    cyc(1, 8'hF0, 0, 0, 1, "ff1");
    cyc(1, 8'h1C, 0, 0, 1, "ff_1c");
    chk("ff_cnt", 32'(evt_count), 32'd1);
    chk("ff_ev", 32'(evt_data), 32'h01C);
    drain("drain4");

    // Interrupt request.
    irq_en = 1;
    cyc(1, 8'h12, 0, 0, 1, "irq_push");
    chk("irq_on", 32'(irq), 32'd1);
    cyc(0, 8'h00, 1, 0, 1, "irq_pop");
    chk("irq_off", 32'(irq), 32'd0);
    cyc(0, 8'h00, 1, 0, 1, "pop_empty");
    chk("pop_empty_cnt", 32'(evt_count), 32'd0);

    // Fill past full.
    for (int i = 1; i <= 9; i++) cyc(1, 8'(i), 0, 0, 1, "fill");
    chk("full_cnt", 32'(evt_count), 32'd8);
`ifdef PS2_KEY_EVENT_OVF_EN
    chk("ovf_set", 32'(overflow), 32'd1);
`else
    chk("ovf_off", 32'(overflow), 32'd0);
`endif
    cyc(0, 8'h00, 0, 1, 1, "ovf_clr");
    chk("ovf_cleared", 32'(overflow), 32'd0);
    // Push with pop while full.
    cyc(1, 8'h0A, 1, 0, 1, "full_pp");
    chk("fpp_cnt", 32'(evt_count), 32'd8);
    chk("fpp_head", 32'(evt_data), 32'h002);
    chk("fpp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1, 0, 1, "to_tail");
    chk("tail_0A", 32'(evt_data), 32'h00A);

    // Reset in the middle of an E0 prefix.
    cyc(1, 8'hE0, 0, 0, 1, "mid_e0");
    do_reset("mid");
    cyc(1, 8'h1C, 0, 0, 1, "post_rst");
    chk("post_rst_ev", 32'(evt_data), 32'h01C);
    drain("drain5");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d;
      bit v, p, c;
      case ($urandom_range(0, 5))
        0:       d = 8'hE0;
        1:       d = 8'hF0;
        default: d = 8'($urandom);
      endcase
      v = ($urandom_range(0, 9) < 6);
      p = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 7) == 0);
      irq_en = 1'($urandom);
      cyc(v, d, p, c, 1, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
Sequences raw bytes from the PS/2 byte decoder into complete key events. A prefix state machine merges E0 (extended) and F0 (break) prefixes with the following scan code into one event word. Events are buffered in a show-ahead FIFO for the M68K-side bus logic. The block also drives the decoder's interrupt-clear and raises a CPU interrupt request while events are pending.

Parameters:
DEPTH, 8, FIFO depth in events; must be a power of 2, minimum 2
TIMEOUT_CYCLES, 25000, idle clocks in a prefix state before abandoning the prefix (1 ms at 25 MHz)

Ports:
clk  input  1  system clock, 25 MHz
reset  input  1  asynchronous, active-high reset
in_valid  input  1  one-cycle pulse from the decoder: in_data is a good byte
in_data  input  8  decoded byte from the decoder
dec_int_clear  output  1  one-cycle pulse to the decoder int_clear
irq_en  input  1  interrupt enable
rd_pop  input  1  one-cycle bus strobe that consumes the head event
evt_data  output  10  head event: [9]=break, [8]=extended, [7:0]=code
evt_avail  output  1  FIFO non-empty
evt_count  output  $clog2(DEPTH)+1  number of events held
irq  output  1  irq_en && evt_avail
overflow  output  1  sticky overflow flag (see Optional Feature)
ovf_clear  input  1  clears overflow

Behaviour:
- Reset, asynchronous: FIFO empties; FSM goes to IDLE; timeout counter clears. All outputs are 0: dec_int_clear, evt_data, evt_avail, evt_count, irq and overflow. A reset mid-sequence discards any pending prefix.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
- IDLE:
  - in_data=E0 goes to EXT.
  - in_data=F0 goes to BRK.
  - Any other byte pushes {0,0,code}.
- EXT:
  - F0 goes to EXT_BRK.
  - E0 stays in EXT.
  - Any other byte pushes {0,1,code} and returns to IDLE.
- BRK:
  - E0 or F0 is a protocol error: return to IDLE, push nothing.
  - Any other byte pushes {1,0,code} and returns to IDLE.
- EXT_BRK:
  - A prefix byte returns to IDLE, push nothing.
  - Any other byte pushes {1,1,code} and returns to IDLE.
- Non-prefix bytes (AA, FA, FE, EE, 00, FF, E1) are pushed unchanged as codes. No special handling.
- Timeout: in any non-IDLE state the counter increments each cycle without in_valid. At TIMEOUT_CYCLES the FSM returns to IDLE. The counter clears on in_valid and in IDLE.
- Push latency: the push occurs on the same clk edge that samples in_valid. evt_avail, evt_count and evt_data update on the following cycle.
- dec_int_clear: registered; pulses for exactly one cycle, the cycle after every sampled in_valid.
- FIFO is show-ahead: evt_data equals the head entry whenever evt_avail=1. evt_data reads 0 when the FIFO is empty.
- rd_pop:
  - When not empty, removes the head. The next entry is visible the following cycle.
  - When empty, it is ignored with no state change.
- Full FIFO:
  - A push without a pop is dropped and sets the overflow condition.
  - A push with a simultaneous pop while full is accepted: count stays DEPTH and no overflow.
- Simultaneous push and pop while not empty: count is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. The count has one extra bit so it can represent DEPTH.
- irq is combinational from registered state, with no glitch on the pop cycle.

Optional Feature:
PS2_KEY_EVENT_OVF_EN
- Defined: overflow sets on a dropped push and stays 1 until ovf_clear. If a drop and ovf_clear occur in the same cycle, set wins.
- Undefined: overflow is tied to 0, ovf_clear is ignored, and drops are silent.

Decomposition:
- Package ps2_ctrl_pkg holds:
  - the FSM state encoding;
  - the constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0;
  - the event-word bit positions EVT_BRK_BIT=9 and EVT_EXT_BIT=8, and EVT_W=10.
- One sub-module, ps2_event_fifo: a parameterised show-ahead synchronous FIFO with push, pop, full, empty and count. The FSM, timeout logic and irq logic stay in the top module.

Test Plan:
- Bytes 1C, then F0 1C -> events 0x01C, 0x21C in order; dec_int_clear pulses 3 times; evt_count=2.
- E0 F0 75 -> single event 0x375; E0 74 -> 0x174; no events pushed for the prefix bytes.
- E0, idle 25001 cycles, then 1C -> event 0x01C (prefix abandoned); F0 F0 1C -> only 0x01C.
- irq_en=1: push 12 → irq=1; rd_pop once → evt_avail=0 and irq=0 the next cycle; rd_pop while empty → no change.
- DEPTH=8: push 9 codes 01..09 → count=8, 09 dropped, overflow=1 (macro on) or 0 (macro off); ovf_clear → 0.
- At full, push 0A with simultaneous rd_pop → count stays 8, head becomes 02, tail is 0A; assert reset mid-E0 → everything reads 0, the next 1C yields 0x01C.
